// File: rtl/qdrc_user_arb.sv
`default_nettype none
// ============================================================================
// Module   : qdrc_user_arb
// Purpose  : Round-robin two-port arbiter for a QDR command port, gated by PHY
//            calibration, with tag-routed fixed-latency read return.
// Revision : 1.0 - initial release
// ============================================================================
module qdrc_user_arb #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 36,
  parameter int BE_W       = 4,
  parameter int RD_LATENCY = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              phy_rdy,
  input  logic              cal_fail,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [BE_W-1:0]   a_be,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [BE_W-1:0]   b_be,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              qdr_wr_en,
  output logic              qdr_rd_en,
  output logic [ADDR_W-1:0] qdr_addr,
  output logic [DATA_W-1:0] qdr_wdata,
  output logic [BE_W-1:0]   qdr_be,
  input  logic [DATA_W-1:0] qdr_rdata,
  output logic              arb_err,
  output logic [1:0]        arb_state_prb
);

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    RUN      = 2'd1,
    FAIL     = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant_b;
  logic   grant_b;
  logic   rd_en_nxt;

  // Tag pipeline: entry k describes the command that left the port k cycles ago
  logic [RD_LATENCY:0] tag_vld;
  logic [RD_LATENCY:0] tag_id;

  always_comb begin
    state_nxt = state;
    grant_b   = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    case (state)
      WAIT_CAL: begin
        if (phy_rdy) state_nxt = cal_fail ? FAIL : RUN;
      end
      RUN: begin
        if (!phy_rdy) begin
          state_nxt = WAIT_CAL;
        end else begin
          grant_b = (a_req && b_req) ? !last_grant_b : b_req;
          a_ack   = a_req && !grant_b;
          b_ack   = b_req && grant_b;
        end
      end
      FAIL: begin
        state_nxt = FAIL;
      end
      default: state_nxt = WAIT_CAL;
    endcase
  end

  assign rd_en_nxt     = (a_ack && !a_wr) || (b_ack && !b_wr);
  assign arb_state_prb = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_CAL;
      last_grant_b <= 1'b1;
      arb_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == FAIL) arb_err <= 1'b1;
      if (a_ack || b_ack) last_grant_b <= b_ack;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qdr_wr_en <= 1'b0;
      qdr_rd_en <= 1'b0;
      qdr_addr  <= '0;
      qdr_wdata <= '0;
      qdr_be    <= '0;
    end else begin
      qdr_wr_en <= (a_ack && a_wr) || (b_ack && b_wr);
      qdr_rd_en <= rd_en_nxt;
      if (a_ack) begin
        qdr_addr  <= a_addr;
        qdr_wdata <= a_wdata;
        qdr_be    <= a_be;
      end else if (b_ack) begin
        qdr_addr  <= b_addr;
        qdr_wdata <= b_wdata;
        qdr_be    <= b_be;
      end
    end
  end

  // Entry 0 is loaded alongside the command register, so it tracks qdr_rd_en
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[RD_LATENCY-1:0], rd_en_nxt};
      tag_id  <= {tag_id[RD_LATENCY-1:0], b_ack};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= tag_vld[RD_LATENCY] && !tag_id[RD_LATENCY];
      b_rvalid <= tag_vld[RD_LATENCY] && tag_id[RD_LATENCY];
      if (tag_vld[RD_LATENCY] && !tag_id[RD_LATENCY]) a_rdata <= qdr_rdata;
      if (tag_vld[RD_LATENCY] && tag_id[RD_LATENCY])  b_rdata <= qdr_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qdrc_user_arb.sv
`default_nettype none
// Testbench for qdrc_user_arb: reference model checked every cycle plus
// directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_qdrc_user_arb;
  localparam int ADDR_W     = 21;
  localparam int DATA_W     = 36;
  localparam int BE_W       = 4;
  localparam int RD_LATENCY = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              phy_rdy = 1'b0;
  logic              cal_fail = 1'b0;
  logic              a_req = 1'b0, a_wr = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0;
  logic [BE_W-1:0]   a_be = '0;
  logic              b_req = 1'b0, b_wr = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic [BE_W-1:0]   b_be = '0;
  logic              a_ack, a_rvalid, b_ack, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              qdr_wr_en, qdr_rd_en, arb_err;
  logic [ADDR_W-1:0] qdr_addr;
  logic [DATA_W-1:0] qdr_wdata;
  logic [BE_W-1:0]   qdr_be;
  logic [DATA_W-1:0] qdr_rdata = '0;
  logic [1:0]        arb_state_prb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  qdrc_user_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .reset_n(reset_n), .phy_rdy(phy_rdy), .cal_fail(cal_fail),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .qdr_wr_en(qdr_wr_en), .qdr_rd_en(qdr_rd_en), .qdr_addr(qdr_addr),
    .qdr_wdata(qdr_wdata), .qdr_be(qdr_be), .qdr_rdata(qdr_rdata),
    .arb_err(arb_err), .arb_state_prb(arb_state_prb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller stand-in: read data bus changes every cycle
  always @(posedge clk) begin
    #1;
    qdr_rdata = qdr_rdata + 36'h1_0000_0003;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; bit id; } pend_t;
  typedef struct { int cyc; bit id; } ev_t;
  pend_t pend[$];
  ev_t   ack_log[$];
  ev_t   rv_log[$];

  int                m_state;    // 0 wait-cal, 1 run, 2 fail
  bit                m_last_b;
  bit                m_wr, m_rd, m_err, m_a_rv, m_b_rv;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_a_rd, m_b_rd;
  logic [BE_W-1:0]   m_be;
  int                tick;
  logic [1:0]        mg;
  logic [1:0]        cg;

  // {b_ack, a_ack} the rules demand for the present inputs
  function automatic logic [1:0] exp_acks();
    if (m_state != 1 || !phy_rdy) return 2'b00;
    if (a_req && b_req) return m_last_b ? 2'b01 : 2'b10;
    return {b_req, a_req};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_last_b = 1'b1; m_wr = 0; m_rd = 0; m_err = 0;
      m_a_rv = 0; m_b_rv = 0; m_addr = '0; m_wdata = '0; m_be = '0;
      m_a_rd = '0; m_b_rd = '0; tick = 0;
      pend.delete();
    end else begin
      mg = exp_acks();
      m_a_rv = 0; m_b_rv = 0;
      if (pend.size() > 0 && pend[0].due == tick) begin
        if (pend[0].id) begin m_b_rv = 1; m_b_rd = qdr_rdata; end
        else            begin m_a_rv = 1; m_a_rd = qdr_rdata; end
        void'(pend.pop_front());
      end
      m_wr = 0; m_rd = 0;
      if (mg != 2'b00) begin
        m_last_b = mg[1];
        m_wr     = mg[1] ? b_wr : a_wr;
        m_rd     = !m_wr;
        m_addr   = mg[1] ? b_addr : a_addr;
        m_wdata  = mg[1] ? b_wdata : a_wdata;
        m_be     = mg[1] ? b_be : a_be;
        if (m_rd) pend.push_back('{tick + RD_LATENCY + 1, mg[1]});
      end
      case (m_state)
        0: if (phy_rdy) m_state = cal_fail ? 2 : 1;
        1: if (!phy_rdy) m_state = 0;
        default: m_state = 2;
      endcase
      m_err = (m_state == 2);
      tick++;
    end
  end

  always @(negedge clk) begin
    cg = exp_acks();
    if (a_ack) ack_log.push_back('{cyc, 1'b0});
    if (b_ack) ack_log.push_back('{cyc, 1'b1});
    if (a_rvalid) rv_log.push_back('{cyc, 1'b0});
    if (b_rvalid) rv_log.push_back('{cyc, 1'b1});
    chk("a_ack", 64'(a_ack), 64'(cg[0]));
    chk("b_ack", 64'(b_ack), 64'(cg[1]));
    chk("qdr_wr_en", 64'(qdr_wr_en), 64'(m_wr));
    chk("qdr_rd_en", 64'(qdr_rd_en), 64'(m_rd));
    chk("qdr_addr", 64'(qdr_addr), 64'(m_addr));
    chk("qdr_wdata", 64'(qdr_wdata), 64'(m_wdata));
    chk("qdr_be", 64'(qdr_be), 64'(m_be));
    chk("a_rvalid", 64'(a_rvalid), 64'(m_a_rv));
    chk("b_rvalid", 64'(b_rvalid), 64'(m_b_rv));
    chk("a_rdata", 64'(a_rdata), 64'(m_a_rd));
    chk("b_rdata", 64'(b_rdata), 64'(m_b_rd));
    chk("arb_err", 64'(arb_err), 64'(m_err));
    chk("state_prb", 64'(arb_state_prb), 64'(m_state));
  end

  // ---------------- directed scenarios ----------------
  initial begin
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;

    // Calibration gate: a held read request is never acknowledged
    a_req = 1; a_wr = 0; a_addr = 21'h5;
    for (int i = 0; i < 100; i++) begin
      step(1); #1;
      chk("cal_gate_ack", 64'(a_ack), 64'd0);
      chk("cal_gate_strobe", 64'(qdr_rd_en | qdr_wr_en), 64'd0);
    end
    phy_rdy = 1; #1;
    chk("ack_before_run", 64'(a_ack), 64'd0);
    step(1); #1;
    chk("first_ack", 64'(a_ack), 64'd1);
    step(1);
    a_req = 0; #1;
    chk("first_rd_en", 64'(qdr_rd_en), 64'd1);
    chk("first_addr", 64'(qdr_addr), 64'h5);
    step(RD_LATENCY + 4);

    // Single write from A
    rv_log.delete();
    a_req = 1; a_wr = 1; a_addr = 21'h10; a_wdata = 36'h123456789; a_be = 4'hF; #1;
    chk("wr_ack", 64'(a_ack), 64'd1);
    step(1);
    a_req = 0; #1;
    chk("wr_en", 64'(qdr_wr_en), 64'd1);
    chk("wr_rd_en", 64'(qdr_rd_en), 64'd0);
    chk("wr_addr", 64'(qdr_addr), 64'h10);
    chk("wr_wdata", 64'(qdr_wdata), 64'h123456789);
    chk("wr_be", 64'(qdr_be), 64'hF);
    step(RD_LATENCY + 4);
    chk("wr_no_rvalid", 64'(rv_log.size()), 64'd0);

    // Dual continuous reads; A was granted last, so B leads
    ack_log.delete(); rv_log.delete();
    a_wr = 0; b_wr = 0; a_addr = 21'h100; b_addr = 21'h200;
    a_req = 1; b_req = 1;
    step(8);
    a_req = 0; b_req = 0;
    step(RD_LATENCY + 4);
    chk("dual_ack_count", 64'(ack_log.size()), 64'd8);
    chk("dual_rv_count", 64'(rv_log.size()), 64'd8);
    if (ack_log.size() == 8 && rv_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("dual_ack_order", 64'(ack_log[i].id), (i % 2 == 0) ? 64'd1 : 64'd0);
        chk("dual_rv_owner", 64'(rv_log[i].id), 64'(ack_log[i].id));
        chk("dual_latency", 64'(rv_log[i].cyc - ack_log[i].cyc), 64'(RD_LATENCY + 2));
      end
    end

    // B read in flight while calibration drops
    ack_log.delete(); rv_log.delete();
    b_req = 1; b_wr = 0; b_addr = 21'h3AB; #1;
    chk("b_ack", 64'(b_ack), 64'd1);
    step(1);
    b_req = 0; phy_rdy = 0; a_req = 1; #1;
    chk("no_ack_phy_low", 64'(a_ack), 64'd0);
    step(1); #1;
    chk("recal_state", 64'(arb_state_prb), 64'd0);
    step(RD_LATENCY + 3);
    chk("recal_ack_count", 64'(ack_log.size()), 64'd1);
    chk("recal_rv_count", 64'(rv_log.size()), 64'd1);
    if (ack_log.size() == 1 && rv_log.size() == 1) begin
      chk("recal_rv_owner", 64'(rv_log[0].id), 64'd1);
      chk("recal_latency", 64'(rv_log[0].cyc - ack_log[0].cyc), 64'(RD_LATENCY + 2));
    end
    phy_rdy = 1;
    step(1); #1;
    chk("resume_ack", 64'(a_ack), 64'd1);
    step(1);
    a_req = 0;
    step(RD_LATENCY + 4);

    // Calibration failure, cleared only by asynchronous reset
    reset_n = 0;
    step(2);
    reset_n = 1; phy_rdy = 1; cal_fail = 1;
    step(1); #1;
    chk("fail_state", 64'(arb_state_prb), 64'd2);
    chk("fail_err", 64'(arb_err), 64'd1);
    a_req = 1;
    step(4); #1;
    chk("fail_no_ack", 64'(a_ack), 64'd0);
    reset_n = 0; #1;
    chk("async_err_clr", 64'(arb_err), 64'd0);
    chk("async_state_clr", 64'(arb_state_prb), 64'd0);
    a_req = 0; cal_fail = 0; phy_rdy = 0;
    step(2);
    reset_n = 1;

    // Reset in the middle of a read burst discards returns
    phy_rdy = 1;
    step(1);
    a_req = 1; b_req = 1; a_wr = 0; b_wr = 0;
    step(4);
    reset_n = 0; a_req = 0; b_req = 0; #1;
    rv_log.delete();
    chk("rst_outputs", 64'({a_rvalid, b_rvalid, qdr_wr_en, qdr_rd_en, arb_err}), 64'd0);
    chk("rst_a_rdata", 64'(a_rdata), 64'd0);
    chk("rst_b_rdata", 64'(b_rdata), 64'd0);
    chk("rst_qdr_addr", 64'(qdr_addr), 64'd0);
    step(3);
    reset_n = 1;
    step(RD_LATENCY + 4);
    chk("rst_no_rvalid", 64'(rv_log.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
